inst_fifo: RTL
==============

Name: inst_fifo

Overview:
Instruction buffer between fetch and the dual-issue decode/issue stage. Fetch pushes up to two {PC, instruction} pairs per cycle. Decode pops one (master only) or two (master + slave) per cycle. Exports empty/almost_empty to the dual-issue detect logic and full to fetch for backpressure. Flushed on branch redirect or exception.

Parameters:
DEPTH, 16, entry count; power of two, >= 4.
DATA_WIDTH, 32, instruction width.
ADDR_WIDTH, 32, PC width.

Ports:
clk  in  1  clock, all state on rising edge.
rst_n  in  1  asynchronous active-low reset.
flush  in  1  discard all entries.
write_en1  in  1  push slot 1.
write_en2  in  1  push slot 2; only meaningful with write_en1.
write_inst1  in  DATA_WIDTH  slot 1 instruction.
write_addr1  in  ADDR_WIDTH  slot 1 PC.
write_inst2  in  DATA_WIDTH  slot 2 instruction.
write_addr2  in  ADDR_WIDTH  slot 2 PC.
read_en1  in  1  pop master (head).
read_en2  in  1  pop slave (head+1); only meaningful with read_en1.
read_inst1  out  DATA_WIDTH  head instruction.
read_addr1  out  ADDR_WIDTH  head PC.
read_inst2  out  DATA_WIDTH  head+1 instruction.
read_addr2  out  ADDR_WIDTH  head+1 PC.
empty  out  1  count == 0.
almost_empty  out  1  count == 1.
full  out  1  fewer than 2 free entries.

Behaviour:
- State: storage array of DEPTH x {addr, inst}, head and tail pointers (log2(DEPTH) bits, wrap modulo DEPTH), and count (log2(DEPTH)+1 bits).
- Reset (async, rst_n = 0): head = tail = count = 0. Outputs: empty = 1, almost_empty = 0, full = 0, all read_* = 0. The storage array is not reset.
- Read side is first-word-fall-through, combinational from head:
  - read_inst1/addr1 = entry[head] if count >= 1, else 0.
  - read_inst2/addr2 = entry[head+1 mod DEPTH] if count >= 2, else 0.
- Status flags are decoded from registered count: empty = (count == 0), almost_empty = (count == 1), full = (count > DEPTH-2).
- Push: pushes = write_en1 + (write_en1 & write_en2).
  - write_en2 without write_en1 is ignored.
  - Slot 1 is written at tail, slot 2 at tail+1. tail advances by pushes.
  - While full = 1, the whole push is dropped (both slots) and state is unchanged by it. Fetch must not rely on a partial accept.
- Pop: requested = read_en1 + (read_en1 & read_en2). pops = min(requested, count), so popping an empty FIFO or a 2-pop with count = 1 saturates. head advances by pops.
- Simultaneous push and pop in one cycle: both apply; count_next = count + pushes - pops. The full check uses current count, not count_next.
- Latency: a pushed entry is visible on read_* and reflected in flags the cycle after the push edge. No same-cycle bypass.
- flush has priority over push and pop in the same cycle: head = tail = count = 0 next cycle and the same-cycle writes are discarded. Outputs then equal reset values.
- Wrap-around: a 2-entry push or pop with the pointer at DEPTH-1 uses indices DEPTH-1 and 0.
- Reset asserted mid-operation clears immediately (asynchronous); all contents are lost.

Optional Feature:
INST_FIFO_STATS_EN.
- Defined: adds output port fifo_count (log2(DEPTH)+1 bits) equal to registered count, and output overflow_seen (1 bit). overflow_seen is sticky: set the cycle after any push attempted while full = 1; cleared only by reset, not by flush.
- Undefined: neither port exists; behaviour is otherwise identical.

Test Plan:
- Reset, then idle -> empty = 1, almost_empty = 0, full = 0, read_inst1 = read_inst2 = 0.
- Push {0xBFC00000, 0x24010001} with write_en1 only -> next cycle almost_empty = 1, read_addr1 = 0xBFC00000, read_inst2 = 0. Then read_en1 = read_en2 = 1 -> count 0, empty = 1 (saturated pop).
- Fill with 2-pushes, DEPTH = 16 -> after 7 cycles count = 14, full = 0; after the 8th, count = 16, full = 1. A further push is dropped (count stays 16); with STATS, overflow_seen = 1 next cycle.
- At count = 5, same cycle 2-push and 2-pop -> count stays 5; head advances by 2; data order preserved (pushed PCs appear after the 3 older entries).
- Wrap: head = tail = 15, count = 0, 2-push PCs A, B -> entries at indices 15 and 0. Next cycle read_addr1 = A, read_addr2 = B; 2-pop -> empty, head = 1.
- count = 6 with flush + 2-push + pop in the same cycle -> next cycle count = 0, empty = 1, read_* = 0. A following push of PC C -> read_addr1 = C.

Source files
------------

// File: rtl/inst_fifo.sv
// rtl/inst_fifo.sv - dual-push/dual-pop FWFT instruction FIFO between fetch and decode
// Optional INST_FIFO_STATS_EN adds fifo_count and sticky overflow_seen outputs.
module inst_fifo #(
    parameter int DEPTH      = 16,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      write_en1,
    input  logic                      write_en2,
    input  logic [DATA_WIDTH-1:0]     write_inst1,
    input  logic [ADDR_WIDTH-1:0]     write_addr1,
    input  logic [DATA_WIDTH-1:0]     write_inst2,
    input  logic [ADDR_WIDTH-1:0]     write_addr2,
    input  logic                      read_en1,
    input  logic                      read_en2,
    output logic [DATA_WIDTH-1:0]     read_inst1,
    output logic [ADDR_WIDTH-1:0]     read_addr1,
    output logic [DATA_WIDTH-1:0]     read_inst2,
    output logic [ADDR_WIDTH-1:0]     read_addr2,
    output logic                      empty,
    output logic                      almost_empty,
`ifdef INST_FIFO_STATS_EN
    output logic [$clog2(DEPTH):0]    fifo_count,
    output logic                      overflow_seen,
`endif
    output logic                      full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_WIDTH-1:0] mem_inst [DEPTH];
    logic [ADDR_WIDTH-1:0] mem_addr [DEPTH];

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;
    logic [PTR_W-1:0] head_p1;
    logic [PTR_W-1:0] tail_p1;
    logic [1:0]       pushes;
    logic [1:0]       pops;
    logic             push_ok;

    assign head_p1 = head + PTR_W'(1);
    assign tail_p1 = tail + PTR_W'(1);

    assign empty        = (count == CNT_W'(0));
    assign almost_empty = (count == CNT_W'(1));
    assign full         = (count > CNT_W'(DEPTH - 2));

    // A push is all-or-nothing: while full both slots are dropped.
    assign push_ok = write_en1 && !full;

    always_comb begin
        pushes = 2'd0;
        if (push_ok) pushes = write_en2 ? 2'd2 : 2'd1;
    end

    // Pops saturate at the current occupancy.
    always_comb begin
        pops = 2'd0;
        if (read_en1) begin
            if (read_en2 && count >= CNT_W'(2)) pops = 2'd2;
            else if (count >= CNT_W'(1))        pops = 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !flush) begin
            mem_inst[tail] <= write_inst1;
            mem_addr[tail] <= write_addr1;
            if (write_en2) begin
                mem_inst[tail_p1] <= write_inst2;
                mem_addr[tail_p1] <= write_addr2;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PTR_W'(pops);
            tail  <= tail + PTR_W'(pushes);
            count <= count + CNT_W'(pushes) - CNT_W'(pops);
        end
    end

    assign read_inst1 = (count >= CNT_W'(1)) ? mem_inst[head]    : '0;
    assign read_addr1 = (count >= CNT_W'(1)) ? mem_addr[head]    : '0;
    assign read_inst2 = (count >= CNT_W'(2)) ? mem_inst[head_p1] : '0;
    assign read_addr2 = (count >= CNT_W'(2)) ? mem_addr[head_p1] : '0;

`ifdef INST_FIFO_STATS_EN
    assign fifo_count = count;

    // Sticky across flush; only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  overflow_seen <= 1'b0;
        else if (write_en1 && full)  overflow_seen <= 1'b1;
    end
`endif

endmodule
